// File: rtl/flag_unit.sv
// NZCV producer with independent NZ/CV banks, a one-deep exception shadow,
// and write-enable gating driven by a per-instruction latched condition.
module flag_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic             ALUCout,
   input  logic             SrcAMsb,
   input  logic             SrcBMsb,
   input  logic [1:0]       ALUControl,
   input  logic [1:0]       FlagW,
   input  logic             EvalEn,
   input  logic             CondEx,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NextPC,
   input  logic             SaveFlags,
   input  logic             RestoreFlags,
   output logic [3:0]       Flags,
   output logic             CondExR,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite
);

   logic [3:0] flags_reg, flags_next;
   logic [3:0] shadow_reg, shadow_next;
   logic       condexr_reg, condexr_next;
   logic [3:0] alu_flags;
   logic       res_msb;

   assign res_msb = ALUResult[WIDTH-1];

   // {N,Z,C,V}; C and V are forced low for logical ops so a stray write is benign
   assign alu_flags[3] = res_msb;
   assign alu_flags[2] = (ALUResult == '0);
   assign alu_flags[1] = ALUCout & ~ALUControl[1];
   assign alu_flags[0] = ~(ALUControl[0] ^ SrcAMsb ^ SrcBMsb)
                       & (SrcAMsb ^ res_msb) & ~ALUControl[1];

   // Bank 1 holds N,Z and bank 0 holds C,V; restore takes priority over writes
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         assign flags_next[gi*2 +: 2] =
            RestoreFlags              ? shadow_reg[gi*2 +: 2] :
            (FlagW[gi] & condexr_reg) ? alu_flags[gi*2 +: 2]  :
                                        flags_reg[gi*2 +: 2];
      end
   endgenerate

   always_comb begin
      shadow_next  = shadow_reg;
      condexr_next = condexr_reg;
      if (SaveFlags)
         shadow_next = flags_reg;
      if (EvalEn)
         condexr_next = CondEx;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_reg   <= 4'b0000;
         shadow_reg  <= 4'b0000;
         condexr_reg <= 1'b0;
      end else begin
         flags_reg   <= flags_next;
         shadow_reg  <= shadow_next;
         condexr_reg <= condexr_next;
      end
   end

   // Gating uses only the latched decision, never CondEx, to avoid a flag loop
   assign Flags    = flags_reg;
   assign CondExR  = condexr_reg;
   assign PCWrite  = (PCS & condexr_reg) | NextPC;
   assign RegWrite = RegW & condexr_reg;
   assign MemWrite = MemW & condexr_reg;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: expectations are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_flag_unit;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] ALUResult;
   logic             ALUCout;
   logic             SrcAMsb;
   logic             SrcBMsb;
   logic [1:0]       ALUControl;
   logic [1:0]       FlagW;
   logic             EvalEn;
   logic             CondEx;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             NextPC;
   logic             SaveFlags;
   logic             RestoreFlags;
   logic [3:0]       Flags;
   logic             CondExR;
   logic             PCWrite;
   logic             RegWrite;
   logic             MemWrite;

   flag_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .ALUResult(ALUResult), .ALUCout(ALUCout),
      .SrcAMsb(SrcAMsb), .SrcBMsb(SrcBMsb), .ALUControl(ALUControl),
      .FlagW(FlagW), .EvalEn(EvalEn), .CondEx(CondEx), .PCS(PCS),
      .RegW(RegW), .MemW(MemW), .NextPC(NextPC), .SaveFlags(SaveFlags),
      .RestoreFlags(RestoreFlags), .Flags(Flags), .CondExR(CondExR),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   eval_seen = 1'b0;

   task automatic push(input string tag, input logic [3:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [3:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty observed=%b required=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_bad++;
            $error("FAIL %s observed=%b required=%b", e.tag, obs, e.val);
         end
         $display("check %s observed=%b expected=%b", e.tag, obs, e.val);
      end
   endtask

   task automatic idle();
      ALUResult = '0; ALUCout = 0; SrcAMsb = 0; SrcBMsb = 0; ALUControl = 2'b00;
      FlagW = 2'b00; EvalEn = 0; CondEx = 0; PCS = 0; RegW = 0; MemW = 0;
      NextPC = 0; SaveFlags = 0; RestoreFlags = 0;
   endtask

   task automatic alu(input logic [1:0] ctrl, input logic [WIDTH-1:0] res,
                      input logic cout, input logic a, input logic b);
      ALUControl = ctrl; ALUResult = res; ALUCout = cout; SrcAMsb = a; SrcBMsb = b;
   endtask

   // Advance one edge and sample 1 time unit later; once a condition has been
   // latched after reset, the latch must never hold X.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (eval_seen) begin
         n_cmp++;
         assert (!$isunknown(CondExR)) else begin
            n_bad++;
            $error("FAIL condexr_known observed=%b required=0/1", CondExR);
         end
      end
   endtask

   task automatic eval(input logic c);
      idle(); EvalEn = 1; CondEx = c;
      cyc();
      eval_seen = 1'b1;
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      cyc(); cyc();
      push("reset_flags", 4'b0000);     pop_check(Flags);
      push("reset_condexr", 4'b0000);   pop_check({3'b000, CondExR});
      PCS = 1; RegW = 1; MemW = 1; #1;
      push("reset_gated_off", 4'b0000); pop_check({1'b0, PCWrite, RegWrite, MemWrite});
      NextPC = 1; #1;
      push("reset_nextpc", 4'b0100);    pop_check({1'b0, PCWrite, RegWrite, MemWrite});
      idle();
      reset = 1'b1;
      cyc();

      eval(1'b1);
      push("condexr_set", 4'b0001);     pop_check({3'b000, CondExR});

      // SUB to zero with carry out
      alu(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      push("sub_zero", 4'b0110);        pop_check(Flags);

      // ADD signed overflow
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      push("add_ovf", 4'b1001);         pop_check(Flags);

      // ADD giving only C, then AND writing NZ only
      alu(2'b00, 32'h0000_0001, 1'b1, 1'b0, 1'b1); FlagW = 2'b11;
      cyc(); idle();
      push("add_carry", 4'b0010);       pop_check(Flags);
      alu(2'b10, 32'h0000_0000, 1'b1, 1'b1, 1'b0); FlagW = 2'b10;
      cyc(); idle();
      push("and_keep_cv", 4'b0110);     pop_check(Flags);

      // Positive gating with condition true
      PCS = 1; RegW = 1; MemW = 1; #1;
      push("gate_pass", 4'b0111);       pop_check({1'b0, PCWrite, RegWrite, MemWrite});
      idle();

      // Condition false suppresses all gated writes and flag updates
      eval(1'b0);
      push("condexr_clear", 4'b0000);   pop_check({3'b000, CondExR});
      PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11;
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0); #1;
      push("gate_block", 4'b0000);      pop_check({1'b0, PCWrite, RegWrite, MemWrite});
      NextPC = 1; #1;
      push("gate_nextpc", 4'b0100);     pop_check({1'b0, PCWrite, RegWrite, MemWrite});
      cyc(); idle();
      push("flags_blocked", 4'b0110);   pop_check(Flags);

      // Save 1000, overwrite, then restore against a concurrent write
      eval(1'b1);
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b1); FlagW = 2'b11;
      cyc(); idle();
      push("set_1000", 4'b1000);        pop_check(Flags);
      SaveFlags = 1;
      cyc(); idle();
      push("save_hold", 4'b1000);       pop_check(Flags);
      alu(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      push("write_0110", 4'b0110);      pop_check(Flags);
      RestoreFlags = 1; FlagW = 2'b11;
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      cyc(); idle();
      push("restore_wins", 4'b1000);    pop_check(Flags);

      // Swap: shadow=1000, flags=0110 -> flags=1000, shadow=0110
      alu(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      SaveFlags = 1; RestoreFlags = 1;
      cyc(); idle();
      push("swap_flags", 4'b1000);      pop_check(Flags);
      RestoreFlags = 1;
      cyc(); idle();
      push("swap_shadow", 4'b0110);     pop_check(Flags);

      // Save captures pre-update flags when a write happens in the same cycle
      SaveFlags = 1; FlagW = 2'b11;
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      cyc(); idle();
      push("save_write", 4'b1001);      pop_check(Flags);
      RestoreFlags = 1;
      cyc(); idle();
      push("save_preupdate", 4'b0110);  pop_check(Flags);

      // EvalEn with a flag write: write uses the old latched decision
      EvalEn = 1; CondEx = 0; FlagW = 2'b11;
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      cyc(); idle();
      push("eval_write_flags", 4'b1001);  pop_check(Flags);
      push("eval_write_condexr", 4'b0000); pop_check({3'b000, CondExR});
      alu(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      push("eval_after_block", 4'b1001);  pop_check(Flags);

      // Reset mid-instruction beats pending writes, save and restore
      eval(1'b1);
      RegW = 1; #1;
      push("pre_reset_regwrite", 4'b0001); pop_check({3'b000, RegWrite});
      reset = 1'b0; FlagW = 2'b11; SaveFlags = 1; RestoreFlags = 1;
      alu(2'b01, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      cyc();
      push("midrst_regwrite", 4'b0000); pop_check({3'b000, RegWrite});
      push("midrst_condexr", 4'b0000);  pop_check({3'b000, CondExR});
      push("midrst_flags", 4'b0000);    pop_check(Flags);
      idle();
      reset = 1'b1;
      eval(1'b1);
      alu(2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b0); FlagW = 2'b11;
      cyc(); idle();
      push("post_rst_write", 4'b1001);  pop_check(Flags);
      RestoreFlags = 1;
      cyc(); idle();
      push("shadow_cleared", 4'b0000);  pop_check(Flags);

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/flag_unit.md
# flag_unit

Flag producer and condition-gating unit for the multi-cycle ARM datapath. It derives NZCV from the ALU result and stores them in two independently writable flag banks. It drives the stored flags to the combinational condition checker and latches the returned `CondEx` once per instruction. Using that latched decision, it gates the architectural write enables (PC, register file, memory) and flag updates issued by the main control FSM. It also holds a one-deep flag shadow for exception entry and return.

## Interface
- `WIDTH`, 32, ALU result width.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ALUResult`  in  WIDTH  ALU output for the current cycle.
- `ALUCout`  in  1  ALU adder carry-out.
- `SrcAMsb`, `SrcBMsb`  in  1 each  operand MSBs as presented to the adder.
- `ALUControl`  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- `FlagW`  in  2  bit1 = write N,Z; bit0 = write C,V (from decoder, asserted in the ALU-execute state).
- `EvalEn`  in  1  FSM decode-state strobe; latch `CondEx`.
- `CondEx`  in  1  condition result from the checker, computed from `Flags`.
- `PCS`, `RegW`, `MemW`  in  1 each  ungated FSM write requests.
- `NextPC`  in  1  unconditional PC write (fetch).
- `SaveFlags`, `RestoreFlags`  in  1 each  exception entry / return strobes.
- `Flags`  out  4  {N,Z,C,V}, registered.
- `CondExR`  out  1  latched condition decision.
- `PCWrite`, `RegWrite`, `MemWrite`  out  1 each  gated enables, combinational.

## Operation
- Flag computation (combinational):
  - `N` = `ALUResult[WIDTH-1]`.
  - `Z` = (`ALUResult` == 0).
  - `C` = `ALUCout` & ~`ALUControl[1]`.
  - `V` = ~(`ALUControl[0]` ^ `SrcAMsb` ^ `SrcBMsb`) & (`SrcAMsb` ^ `ALUResult[WIDTH-1]`) & ~`ALUControl[1]`.
- Condition latch: when `EvalEn`=1, `CondExR` <= `CondEx`. Otherwise it holds. The decision stays valid for all later states of the same instruction.
- Flag write:
  - Bank NZ updates when `FlagW[1]` & `CondExR`.
  - Bank CV updates when `FlagW[0]` & `CondExR`.
  - The banks are independent. Logical ops issued with `FlagW`=10 leave C and V unchanged.
- Shadow register:
  - `SaveFlags`=1: `Shadow` <= current `Flags`, i.e. the pre-update value in that cycle.
  - `RestoreFlags`=1: `Flags` <= `Shadow`. Restore overrides any `FlagW` write in the same cycle.
  - `SaveFlags` and `RestoreFlags` both 1: `Shadow` <= old `Flags` and `Flags` <= old `Shadow` (swap).
- Gating:
  - `PCWrite` = (`PCS` & `CondExR`) | `NextPC`.
  - `RegWrite` = `RegW` & `CondExR`.
  - `MemWrite` = `MemW` & `CondExR`.
- `CondEx` is not consumed combinationally by gating. This breaks the `Flags` -> checker -> enable loop.
- `EvalEn` in the same cycle as a flag write: `CondExR` captures `CondEx` computed from the old `Flags`. The flag write uses the old `CondExR`.

## Timing
- Reset (`reset`=0 at an edge): `Flags`=0000, `Shadow`=0000, `CondExR`=0. Gated outputs then depend only on `NextPC`.
- `Flags` updates 1 cycle after the `FlagW` cycle.
- `CondExR` is valid 1 cycle after `EvalEn`.
- Gated enables have 0-cycle latency from `PCS`/`RegW`/`MemW`.
- Reset mid-instruction: all state clears, so a pending conditional write is suppressed.
- Reset has priority over `RestoreFlags`, `SaveFlags` and `FlagW`.
- X or undefined condition from the checker must not reach `Flags`. The bench checks that `CondExR` is never X after the first `EvalEn` following reset.

## Test plan
- Reset then SUB with `ALUResult`=0, `ALUCout`=1, MSBs 0/0, `FlagW`=11, `CondExR`=1 -> `Flags`=0110 next cycle.
- ADD overflow: `SrcAMsb`=0, `SrcBMsb`=0, `ALUResult`=0x8000_0000, `ALUCout`=0, `FlagW`=11 -> `Flags`=1001.
- With `Flags`=0010, AND with `FlagW`=10 and `ALUResult`=0 -> `Flags`=0110; C is retained and V stays 0.
- `CondEx`=0 latched at `EvalEn`, then `RegW`=`MemW`=`PCS`=1 and `FlagW`=11 -> `RegWrite`=`MemWrite`=`PCWrite`=0 and `Flags` unchanged. With `NextPC`=1 -> `PCWrite`=1.
- `Flags`=1000 then `SaveFlags`; write `Flags`=0110; then `RestoreFlags` together with `FlagW`=11 -> `Flags`=1000 (restore wins).
- Drive `reset`=0 in the cycle after `EvalEn` with `CondEx`=1 and `RegW`=1 -> `CondExR`=0, `RegWrite`=0, `Flags`=0000 after the edge.
